tt_um_serial_add_ctrl: RTL and testbench
========================================

TT_UM_SERIAL_ADD_CTRL -- requirements
Module: tt_um_serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width; only 8 is supported on this pinout.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ena  input  1  powered indicator; ignored.
REQ-005 SHALL have port ui_in  input  8  operand data bus, sampled on load strobes.
REQ-006 SHALL have port uio_in  input  8  control: [0] ld_a, [1] ld_b, [2] start, [3] ack; [7:4] ignored.
REQ-007 SHALL have port uo_out  output  8  last completed sum.
REQ-008 SHALL have port uio_out  output  8  status: [4] busy, [5] done, [6] carry_out, [7] err; [3:0] driven 0.
REQ-009 SHALL have port uio_oe  output  8  constant 8'hF0.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, DONE; all strobes level-sampled each rising edge.
REQ-011 In IDLE, ld_a high SHALL load ui_in into operand A, and ld_b high SHALL load ui_in into operand B; both high loads both.
REQ-012 In IDLE, start high with ld_a and ld_b low SHALL clear carry and bit counter and enter RUN.
REQ-013 In IDLE, start high together with any load SHALL perform the load only and remain in IDLE.
REQ-014 Each RUN cycle SHALL compute one bit: sum = A[0]^B[0]^c, c' = majority(A[0],B[0],c), via two half-adder cells plus OR.
REQ-015 Each RUN cycle SHALL shift A and B right by one and shift the sum bit into the partial-sum register MSB.
REQ-016 A 3-bit counter SHALL count RUN cycles; after the 8th RUN edge (counter wrap 7->0) the FSM SHALL enter DONE.
REQ-017 On entering DONE, the partial sum SHALL be copied to the result register (uo_out) and the final carry to carry_out.
REQ-018 Latency SHALL be: start sampled at edge N, done high after edge N+8.
REQ-019 busy SHALL be high exactly while in RUN; done SHALL be high exactly while in DONE.
REQ-020 In DONE, ack high SHALL return to IDLE; start in the same cycle SHALL be ignored.
REQ-021 In DONE without ack, start/ld_a/ld_b SHALL be ignored and not set err.
REQ-022 In RUN, any of ld_a, ld_b, start high SHALL be ignored and SHALL set sticky err.
REQ-023 ack high in any state SHALL clear err; a same-cycle err set and ack SHALL leave err set.
REQ-024 uo_out and carry_out SHALL hold their last completed values in IDLE and RUN until the next DONE entry.
REQ-025 Operands SHALL be consumed destructively; a new computation requires reloading A and B.

Reset
REQ-026 rst_n low SHALL asynchronously force state IDLE and clear A, B, partial sum, counter, carry, result, carry_out, and err to 0.
REQ-027 Reset mid-RUN SHALL abort the computation with no DONE and uo_out = 0.
REQ-028 Outputs after reset: uo_out 8'h00, uio_out 8'h00, uio_oe 8'hF0.

Structure
REQ-029 Package serial_add_pkg SHALL hold the WIDTH constant, the FSM state enum (2-bit encoding), and the uio bit-index constants.
REQ-030 Sub-module ha_cell (1-bit half adder: s = a^b, c = a&b) SHALL be instantiated twice to form the full-adder bit slice.
REQ-031 Implementation SHALL be synthesizable with no latches and no combinational loops.

Verification
REQ-032 Scenario: ld_a=0x3C, ld_b=0x05, start -> done after 8 further edges, uo_out=0x41, carry_out=0, busy high for 8 cycles.
REQ-033 Scenario: A=0xFF, B=0x01, start -> uo_out=0x00, carry_out=1, done set.
REQ-034 Scenario: ld_a pulse with ui_in=0xAA during RUN -> err=1, result unchanged from the correct sum, err cleared by ack.
REQ-035 Scenario: rst_n low at 4th RUN cycle -> busy=0, done=0, uo_out=0x00 immediately (asynchronous), state IDLE.
REQ-036 Scenario: start and ld_b (ui_in=0x10) in the same IDLE cycle -> B=0x10, busy stays 0; next start runs with new B.
REQ-037 Scenario: ack with start in DONE -> IDLE, no RUN; back-to-back reload/start gives correct second sum 0x80+0x80 -> 0x00, carry_out=1.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder controller: operand width,
// FSM state encoding and the bit positions used on the uio bus.
package serial_add_pkg;

  localparam int SA_WIDTH = 8;
  localparam int CNT_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int LD_A_BIT  = 0;
  localparam int LD_B_BIT  = 1;
  localparam int START_BIT = 2;
  localparam int ACK_BIT   = 3;
  localparam int BUSY_BIT  = 4;
  localparam int DONE_BIT  = 5;
  localparam int COUT_BIT  = 6;
  localparam int ERR_BIT   = 7;

endpackage

// File: rtl/ha_cell.sv
// One-bit half adder; two of these plus an OR make the serial full-adder slice.
module ha_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/tt_um_serial_add_ctrl.sv
// Bit-serial 8-bit adder: operands loaded over ui_in, one bit summed per RUN
// cycle LSB first, result and carry held on the outputs until the next run.
module tt_um_serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   psum;
  logic [WIDTH-1:0]   psum_nxt;
  logic [WIDTH-1:0]   result;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic               carry_out;
  logic               err;
  logic               busy;
  logic               done;
  logic               last_bit;
  logic               err_set;

  logic ld_a, ld_b, start, ack;
  assign ld_a  = uio_in[LD_A_BIT];
  assign ld_b  = uio_in[LD_B_BIT];
  assign start = uio_in[START_BIT];
  assign ack   = uio_in[ACK_BIT];

  logic unused_in;
  assign unused_in = &{1'b0, ena, uio_in[7:4]};

  logic s0, c0, bit_sum, c1, carry_nxt;

  ha_cell u_ha0 (.a(op_a[0]), .b(op_b[0]), .s(s0),      .c(c0));
  ha_cell u_ha1 (.a(s0),      .b(carry),   .s(bit_sum), .c(c1));

  assign carry_nxt = c0 | c1;
  assign psum_nxt  = {bit_sum, psum[WIDTH-1:1]};
  assign last_bit  = (cnt == {CNT_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    err_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !ld_a && !ld_b) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy    = 1'b1;
        err_set = ld_a | ld_b | start;
        if (last_bit) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operands shift out LSB first; the sum bit enters psum at the MSB so that
  // after WIDTH cycles psum holds the full word in natural order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a      <= '0;
      op_b      <= '0;
      psum      <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ld_a) op_a <= ui_in[WIDTH-1:0];
          if (ld_b) op_b <= ui_in[WIDTH-1:0];
          if (state_nxt == ST_RUN) begin
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          psum  <= psum_nxt;
          carry <= carry_nxt;
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            result    <= psum_nxt;
            carry_out <= carry_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // A set and a clear in the same cycle resolve to set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err <= 1'b0;
    else if (err_set) err <= 1'b1;
    else if (ack)     err <= 1'b0;
  end

  assign uo_out  = result;
  assign uio_out = {err, carry_out, done, busy, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_serial_add_ctrl.sv
// Randomised bench for the serial adder controller with an arithmetic model
// of the expected sum, status flags and error behaviour.
module tb_tt_um_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  localparam logic [7:0] LDA = 8'h01;
  localparam logic [7:0] LDB = 8'h02;
  localparam logic [7:0] ST  = 8'h04;
  localparam logic [7:0] AK  = 8'h08;

  tt_um_serial_add_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 running, 2 done; the sum is plain 9-bit addition.
  int         m_mode = 0;
  int         m_left = 0;
  logic [7:0] m_a = 0, m_b = 0, m_res = 0;
  logic [8:0] m_total = 0;
  logic       m_cout = 0, m_err = 0;

  always @(posedge clk or negedge rst_n) begin : model
    logic la, lb, st, ak, eset;
    if (!rst_n) begin
      m_mode = 0; m_left = 0; m_a = 0; m_b = 0; m_res = 0;
      m_total = 0; m_cout = 0; m_err = 0;
    end else begin
      la = uio_in[0]; lb = uio_in[1]; st = uio_in[2]; ak = uio_in[3];
      eset = (m_mode == 1) && (la || lb || st);
      case (m_mode)
        0: begin
          if (st && !la && !lb) begin
            m_total = {1'b0, m_a} + {1'b0, m_b};
            m_left  = 8;
            m_mode  = 1;
          end
          if (la) m_a = ui_in;
          if (lb) m_b = ui_in;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_res  = m_total[7:0];
            m_cout = m_total[8];
            m_a    = 8'h00;
            m_b    = 8'h00;
            m_mode = 2;
          end
        end
        default: if (ak) m_mode = 0;
      endcase
      if (eset)    m_err = 1'b1;
      else if (ak) m_err = 1'b0;
    end
  end

  function automatic logic [7:0] m_status();
    return {m_err, m_cout, m_mode == 2, m_mode == 1, 4'b0000};
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_uo_out", uo_out, m_res);
      check("cyc_uio_out", uio_out, m_status());
      check("cyc_uio_oe", uio_oe, 8'hF0);
    end
  end

  task automatic drive(input logic [7:0] u, input logic [7:0] c);
    ui_in  = u;
    uio_in = c;
    @(posedge clk);
    #1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
  endtask

  task automatic run_sum(input logic [7:0] a, input logic [7:0] b);
    drive(a, LDA);
    drive(b, LDB);
    drive(8'h00, ST);
    repeat (8) drive(8'h00, 8'h00);
  endtask

  initial begin
    logic [7:0] c;
    #12;
    check("rst_uo_out", uo_out, 8'h00);
    check("rst_uio_out", uio_out, 8'h00);
    check("rst_uio_oe", uio_oe, 8'hF0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cmp_en = 1'b1;

    // 0x3C + 0x05 with busy counted cycle by cycle
    drive(8'h3C, LDA);
    drive(8'h05, LDB);
    drive(8'h00, ST);
    for (int i = 0; i < 8; i++) begin
      check("s1_busy", {7'b0, uio_out[4]}, 8'h01);
      drive(8'h00, 8'h00);
    end
    check("s1_done", uio_out, 8'h20);
    check("s1_sum", uo_out, 8'h41);
    check("s1_model", m_res, 8'h41);
    drive(8'h00, AK);
    check("s1_idle", uio_out, 8'h00);

    // 0xFF + 0x01 overflows
    run_sum(8'hFF, 8'h01);
    check("s2_sum", uo_out, 8'h00);
    check("s2_status", uio_out, 8'h60);
    check("s2_model_cout", {7'b0, m_cout}, 8'h01);
    drive(8'h00, AK);

    // strobes during RUN, including a same-cycle set and ack
    drive(8'h12, LDA);
    drive(8'h34, LDB);
    drive(8'h00, ST);
    drive(8'hAA, LDA);
    drive(8'h00, ST | AK);
    check("s3_err_kept", {7'b0, uio_out[7]}, 8'h01);
    drive(8'h00, AK);
    check("s3_err_clr", {7'b0, uio_out[7]}, 8'h00);
    drive(8'h00, LDB);
    repeat (4) drive(8'h00, 8'h00);
    check("s3_sum", uo_out, 8'h46);
    check("s3_status", uio_out, 8'hA0);
    drive(8'h00, AK);
    check("s3_ack", uio_out, 8'h00);

    // asynchronous reset in the 4th RUN cycle
    drive(8'h11, LDA);
    drive(8'h22, LDB);
    drive(8'h00, ST);
    repeat (3) drive(8'h00, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    check("s4_rst_uo", uo_out, 8'h00);
    check("s4_rst_uio", uio_out, 8'h00);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("s4_after", uio_out, 8'h00);

    // start together with a load only loads
    drive(8'h01, LDA);
    drive(8'h10, ST | LDB);
    check("s5_no_run", uio_out, 8'h00);
    drive(8'h00, ST);
    repeat (8) drive(8'h00, 8'h00);
    check("s5_sum", uo_out, 8'h11);

    // ack with start in DONE, then back-to-back run
    drive(8'h00, ST | AK);
    drive(8'h00, 8'h00);
    check("s6_no_run", uio_out, 8'h00);
    run_sum(8'h80, 8'h80);
    check("s6_sum", uo_out, 8'h00);
    check("s6_status", uio_out, 8'h60);

    // strobes ignored in DONE, then a run on consumed operands
    drive(8'h55, LDA | LDB | ST);
    check("s7_done_hold", uio_out, 8'h60);
    drive(8'h00, AK);
    drive(8'h00, ST);
    repeat (8) drive(8'h00, 8'h00);
    check("s7_sum", uo_out, 8'h00);
    check("s7_status", uio_out, 8'h20);
    drive(8'h00, AK);

    for (int i = 0; i < 600; i++) begin
      c = {4'($urandom_range(15, 0)), 4'b0000};
      if ($urandom_range(4, 0) == 0) c = c | LDA;
      if ($urandom_range(4, 0) == 0) c = c | LDB;
      if ($urandom_range(3, 0) == 0) c = c | ST;
      if ($urandom_range(9, 0) == 0) c = c | AK;
      drive(8'($urandom), c);
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
